exception_unit: RTL and testbench
=================================

Name: exception_unit

Overview:
- Parametrised successor to the datapath's fixed two-cause EPC/Cause logic (opcode-invalid / overflow).
- Accepts NUM_CAUSES one-hot-or-multi exception requests and arbitrates them by fixed priority.
- Captures EPC and Cause, fetches the handler address byte from a memory vector table, and redirects the PC.
- Also handles return-from-exception, restoring the PC from EPC. Sits between the control unit, the memory read port mux and the PC source mux.

Parameters:
- WIDTH, 32, datapath/address width.
- NUM_CAUSES, 4, number of exception request lines (>=2).
- VECTOR_BASE, 254, byte address of vector-table entry for cause 0; entry i is at VECTOR_BASE+i.
- MEM_LATENCY, 1, cycles from mem_rd_req to valid mem_rd_data (>=1).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- exc_req  in  NUM_CAUSES  exception request pulses; bit i = cause i.
- pc_exc  in  WIDTH  address of the faulting instruction, valid with exc_req.
- eret  in  1  return-from-exception pulse from the control unit.
- mem_rd_req  out  1  vector-table read request.
- mem_rd_addr  out  WIDTH  vector-table address.
- mem_rd_data  in  WIDTH  memory read data; bits [7:0] hold the handler address.
- pc_load  out  1  one-cycle strobe: load pc_next into PC.
- pc_next  out  WIDTH  redirect target.
- epc  out  WIDTH  Exception Program Counter.
- cause  out  WIDTH  index of the serviced cause, zero-extended.
- in_handler  out  1  set from redirect until eret.
- busy  out  1  high while the FSM is not IDLE.
- exc_lost  out  1  sticky flag: a request was dropped.

Behaviour:
- Reset: synchronous, active-high. Every register is cleared and the FSM enters IDLE.
- Reset values: epc=0, cause=0, pc_next=0, pc_load=0, mem_rd_req=0, mem_rd_addr=0, in_handler=0, busy=0, exc_lost=0. A mid-operation reset aborts the sequence with no pc_load.
- FSM states: IDLE, VEC_REQ, VEC_WAIT, REDIRECT, ERET_OUT.
- IDLE, accept condition: exc_req!=0 and in_handler=0.
  - Select the lowest set index k (lowest index = highest priority).
  - At the edge: epc<=pc_exc, cause<=k, go to VEC_REQ.
  - Other bits set in the same cycle are dropped and set exc_lost.
- Requests arriving while busy=1 or in_handler=1 are dropped and set exc_lost. epc and cause are unchanged.
- VEC_REQ, one cycle: mem_rd_req=1, mem_rd_addr=VECTOR_BASE+cause (WIDTH-bit add, wraps). Load the wait counter with MEM_LATENCY-1, go to VEC_WAIT.
- VEC_WAIT: counter decrements each cycle. When it reaches 0, at that edge pc_next<={0, mem_rd_data[7:0]}, go to REDIRECT.
- REDIRECT, one cycle: pc_load=1. At the edge: in_handler<=1, go to IDLE.
- Exception latency: request at cycle 0 → pc_load high in cycle 2+MEM_LATENCY.
- busy is high from cycle 1 through REDIRECT inclusive.
- ERET: in IDLE with in_handler=1 and eret=1, at the edge pc_next<=epc, in_handler<=0, go to ERET_OUT.
  - ERET_OUT, one cycle: pc_load=1, then go to IDLE.
  - eret while in_handler=0 or busy=1 is ignored.
- Simultaneous eret and exc_req in IDLE with in_handler=1: eret wins, and the request is dropped (exc_lost<=1).
- exc_lost is cleared only by reset.
- epc and cause hold their values until the next accepted exception; eret does not clear them.
- pc_load is never asserted for two consecutive cycles.

Decomposition:
- Shared package exc_pkg:
  - typedef enum logic [2:0] exc_state_t {IDLE, VEC_REQ, VEC_WAIT, REDIRECT, ERET_OUT};
  - localparam CAUSE_OVERFLOW=1, CAUSE_OPCODE=0;
  - function for the priority index width ($clog2(NUM_CAUSES)).
- One sub-module: exc_priority_enc. It is a parameterised lowest-index-first encoder with outputs idx, any and multi (more than one bit set).
- The FSM, counter and registers stay in exception_unit.

Test Plan:
- Single request: NUM_CAUSES=4, MEM_LATENCY=1, exc_req=4'b0010, pc_exc=0x40, memory[255]=0x8C → epc=0x40, cause=1, mem_rd_addr=255 in cycle 1, pc_load with pc_next=0x8C in cycle 3, in_handler=1 afterwards.
- Priority: exc_req=4'b1010, pc_exc=0x100 → cause=1, exc_lost=1, vector read at 255.
- Nested drop: during busy and after redirect, pulse exc_req=4'b0001 → epc and cause unchanged, no second redirect, exc_lost=1.
- ERET: after the first scenario, eret=1 → next cycle pc_load=1, pc_next=0x40, in_handler=0. A second eret is ignored.
- Latency parameter: MEM_LATENCY=3, exc_req=4'b0001 → mem_rd_req only in cycle 1, pc_load in cycle 5, busy high in cycles 1–5.
- Reset mid-sequence: assert reset in VEC_WAIT → next cycle all outputs are 0, no pc_load. A fresh request is then serviced normally.

Source files
------------

// File: rtl/exc_pkg.sv
// Shared types and helpers for the exception unit: FSM state encoding,
// well-known cause numbers and the priority-index width helper.
package exc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VEC_REQ,
    VEC_WAIT,
    REDIRECT,
    ERET_OUT
  } exc_state_t;

  localparam int CAUSE_OPCODE   = 0;
  localparam int CAUSE_OVERFLOW = 1;

  function automatic int idx_width(input int num_causes);
    return (num_causes > 1) ? $clog2(num_causes) : 1;
  endfunction

endpackage

// File: rtl/exc_priority_enc.sv
// Lowest-index-first priority encoder; also flags when more than one
// request bit is set so the caller can record the dropped ones.
module exc_priority_enc
  import exc_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          any,
  output logic          multi
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int unsigned i = N; i > 0; i--) begin
      if (req[i-1]) idx = IW'(i - 1);
    end
  end

  assign any   = |req;
  assign multi = |(req & (req - N'(1)));

endmodule

// File: rtl/exception_unit.sv
// Exception sequencer: arbitrates cause requests, captures EPC/Cause,
// fetches the handler address from the vector table and redirects the PC.
module exception_unit
  import exc_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int NUM_CAUSES  = 4,
  parameter int VECTOR_BASE = 254,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_CAUSES-1:0] exc_req,
  input  logic [WIDTH-1:0]      pc_exc,
  input  logic                  eret,
  output logic                  mem_rd_req,
  output logic [WIDTH-1:0]      mem_rd_addr,
  input  logic [WIDTH-1:0]      mem_rd_data,
  output logic                  pc_load,
  output logic [WIDTH-1:0]      pc_next,
  output logic [WIDTH-1:0]      epc,
  output logic [WIDTH-1:0]      cause,
  output logic                  in_handler,
  output logic                  busy,
  output logic                  exc_lost
);

  localparam int IW = idx_width(NUM_CAUSES);
  localparam int CW = $clog2(MEM_LATENCY + 1);

  exc_state_t     state;
  logic [CW-1:0]  wait_cnt;
  logic [IW-1:0]  req_idx;
  logic           req_any;
  logic           req_multi;
  logic           unused_data;

  assign unused_data = ^mem_rd_data[WIDTH-1:8];

  exc_priority_enc #(
    .N  (NUM_CAUSES),
    .IW (IW)
  ) u_enc (
    .req   (exc_req),
    .idx   (req_idx),
    .any   (req_any),
    .multi (req_multi)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      mem_rd_req  <= 1'b0;
      mem_rd_addr <= '0;
      pc_load     <= 1'b0;
      pc_next     <= '0;
      epc         <= '0;
      cause       <= '0;
      in_handler  <= 1'b0;
      busy        <= 1'b0;
      exc_lost    <= 1'b0;
    end else begin
      if (state != IDLE && req_any) exc_lost <= 1'b1;

      case (state)
        IDLE: begin
          if (in_handler && eret) begin
            pc_next    <= epc;
            in_handler <= 1'b0;
            pc_load    <= 1'b1;
            busy       <= 1'b1;
            state      <= ERET_OUT;
            if (req_any) exc_lost <= 1'b1;
          end else if (!in_handler && req_any) begin
            epc         <= pc_exc;
            cause       <= WIDTH'(req_idx);
            // Request/address are registered here so they are visible
            // throughout VEC_REQ.
            mem_rd_req  <= 1'b1;
            mem_rd_addr <= WIDTH'(VECTOR_BASE) + WIDTH'(req_idx);
            busy        <= 1'b1;
            state       <= VEC_REQ;
            if (req_multi) exc_lost <= 1'b1;
          end else if (req_any) begin
            exc_lost <= 1'b1;
          end
        end
        VEC_REQ: begin
          mem_rd_req <= 1'b0;
          wait_cnt   <= CW'(MEM_LATENCY - 1);
          state      <= VEC_WAIT;
        end
        VEC_WAIT: begin
          if (wait_cnt == '0) begin
            pc_next <= WIDTH'(mem_rd_data[7:0]);
            pc_load <= 1'b1;
            state   <= REDIRECT;
          end else begin
            wait_cnt <= wait_cnt - CW'(1);
          end
        end
        REDIRECT: begin
          pc_load    <= 1'b0;
          in_handler <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        ERET_OUT: begin
          pc_load <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exception_unit.sv
// Bench for exception_unit: two instances (memory latency 1 and 3), a
// timeline-based reference model checked every cycle, plus literal checks.
module tb_exception_unit;
  import exc_pkg::*;

  localparam int VB = 254;

  logic        clock = 1'b0;
  logic        rst    [2];
  logic [3:0]  req    [2];
  logic [31:0] pcx    [2];
  logic        er     [2];
  logic        rdreq  [2];
  logic [31:0] rdaddr [2];
  logic [31:0] rdata  [2];
  logic        pcload [2];
  logic [31:0] pcnext [2];
  logic [31:0] o_epc  [2];
  logic [31:0] o_cause[2];
  logic        inh    [2];
  logic        bsy    [2];
  logic        lost   [2];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  exception_unit #(.WIDTH(32), .NUM_CAUSES(4), .VECTOR_BASE(VB), .MEM_LATENCY(1)) dut0 (
    .clock(clock), .reset(rst[0]), .exc_req(req[0]), .pc_exc(pcx[0]), .eret(er[0]),
    .mem_rd_req(rdreq[0]), .mem_rd_addr(rdaddr[0]), .mem_rd_data(rdata[0]),
    .pc_load(pcload[0]), .pc_next(pcnext[0]), .epc(o_epc[0]), .cause(o_cause[0]),
    .in_handler(inh[0]), .busy(bsy[0]), .exc_lost(lost[0]));

  exception_unit #(.WIDTH(32), .NUM_CAUSES(4), .VECTOR_BASE(VB), .MEM_LATENCY(3)) dut1 (
    .clock(clock), .reset(rst[1]), .exc_req(req[1]), .pc_exc(pcx[1]), .eret(er[1]),
    .mem_rd_req(rdreq[1]), .mem_rd_addr(rdaddr[1]), .mem_rd_data(rdata[1]),
    .pc_load(pcload[1]), .pc_next(pcnext[1]), .epc(o_epc[1]), .cause(o_cause[1]),
    .in_handler(inh[1]), .busy(bsy[1]), .exc_lost(lost[1]));

  function automatic logic [31:0] memval(input logic [31:0] a);
    case (a)
      32'd254: return 32'h1234_5677;
      32'd255: return 32'hDEAD_BE8C;
      32'd256: return 32'hCAFE_003C;
      32'd257: return 32'h0BAD_F05A;
      default: return 32'hFFFF_FFEE;
    endcase
  endfunction

  // Vector-table memory: data valid exactly `latency` cycles after the request.
  logic        dv [2][3];
  logic [31:0] da [2][3];
  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      dv[i][0] <= rdreq[i];
      da[i][0] <= rdaddr[i];
      for (int s = 1; s < 3; s++) begin
        dv[i][s] <= dv[i][s-1];
        da[i][s] <= da[i][s-1];
      end
    end
  end
  assign rdata[0] = dv[0][0] ? memval(da[0][0]) : 32'hFFFF_FFEE;
  assign rdata[1] = dv[1][2] ? memval(da[1][2]) : 32'hFFFF_FFEE;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: remembers when the current sequence was accepted and
  // derives each cycle's outputs from the offset into that sequence.
  int          cyc = 0;
  bit          model_ok = 0;
  int          kind   [2];
  int          acc_t  [2];
  int          k_m    [2];
  logic [31:0] pca_m  [2];
  logic        e_rdreq[2], e_pcload[2], e_busy[2], e_inh[2], e_lost[2];
  logic [31:0] e_addr[2], e_pcnext[2], e_epc[2], e_cause[2];

  function automatic int lowest(input logic [3:0] r);
    for (int i = 0; i < 4; i++) if (r[i]) return i;
    return -1;
  endfunction

  initial begin
    forever begin
      @(posedge clock);
      for (int i = 0; i < 2; i++) begin
        int d, lat;
        logic [31:0] v;
        lat = (i == 0) ? 1 : 3;
        if (rst[i]) begin
          kind[i] = 0; acc_t[i] = 0;
          e_rdreq[i] = 0; e_pcload[i] = 0; e_busy[i] = 0; e_inh[i] = 0; e_lost[i] = 0;
          e_addr[i] = 0; e_pcnext[i] = 0; e_epc[i] = 0; e_cause[i] = 0;
        end else begin
          if (!e_busy[i] && e_inh[i] && er[i]) begin
            kind[i] = 2; acc_t[i] = cyc;
            if (req[i] != 0) e_lost[i] = 1;
          end else if (!e_busy[i] && !e_inh[i] && req[i] != 0) begin
            kind[i] = 1; acc_t[i] = cyc; k_m[i] = lowest(req[i]); pca_m[i] = pcx[i];
            if ($countones(req[i]) > 1) e_lost[i] = 1;
          end else if (req[i] != 0) begin
            e_lost[i] = 1;
          end
          d = cyc + 1 - acc_t[i];
          e_rdreq[i] = 0; e_pcload[i] = 0; e_busy[i] = 0;
          if (kind[i] == 1) begin
            if (d == 1) begin
              e_rdreq[i] = 1; e_addr[i] = VB + k_m[i];
              e_epc[i] = pca_m[i]; e_cause[i] = k_m[i];
            end
            e_busy[i] = (d >= 1 && d <= 2 + lat);
            if (d == 2 + lat) begin
              v = memval(VB + k_m[i]);
              e_pcload[i] = 1; e_pcnext[i] = {24'h0, v[7:0]};
            end
            if (d == 3 + lat) e_inh[i] = 1;
          end else if (kind[i] == 2 && d == 1) begin
            e_busy[i] = 1; e_pcload[i] = 1; e_pcnext[i] = e_epc[i]; e_inh[i] = 0;
          end
        end
      end
      cyc++;
      model_ok = 1;
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (model_ok) begin
        for (int i = 0; i < 2; i++) begin
          check($sformatf("dut%0d.mem_rd_req", i),  32'(rdreq[i]),  32'(e_rdreq[i]));
          check($sformatf("dut%0d.mem_rd_addr", i), rdaddr[i],      e_addr[i]);
          check($sformatf("dut%0d.pc_load", i),     32'(pcload[i]), 32'(e_pcload[i]));
          check($sformatf("dut%0d.pc_next", i),     pcnext[i],      e_pcnext[i]);
          check($sformatf("dut%0d.epc", i),         o_epc[i],       e_epc[i]);
          check($sformatf("dut%0d.cause", i),       o_cause[i],     e_cause[i]);
          check($sformatf("dut%0d.in_handler", i),  32'(inh[i]),    32'(e_inh[i]));
          check($sformatf("dut%0d.busy", i),        32'(bsy[i]),    32'(e_busy[i]));
          check($sformatf("dut%0d.exc_lost", i),    32'(lost[i]),   32'(e_lost[i]));
        end
      end
    end
  end

  task automatic cyc_();
    @(posedge clock);
    #1;
  endtask

  logic [7:0] vec_lit [3];

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1; req[i] = 0; pcx[i] = 0; er[i] = 0;
    end
    vec_lit = '{8'h5A, 8'h3C, 8'h77};
    repeat (2) cyc_();
    rst[0] = 0; rst[1] = 0;
    check("lit.reset_epc", o_epc[0], 32'h0);
    check("lit.reset_busy", 32'(bsy[0]), 32'h0);

    // Single request, cause 1
    req[0] = 4'b0010; pcx[0] = 32'h40; cyc_();
    req[0] = 0;
    check("lit.s1_rdreq", 32'(rdreq[0]), 32'h1);
    check("lit.s1_addr", rdaddr[0], 32'd255);
    check("lit.s1_epc", o_epc[0], 32'h40);
    check("lit.s1_cause", o_cause[0], 32'(CAUSE_OVERFLOW));
    cyc_();
    req[0] = 4'b0001; pcx[0] = 32'h777; cyc_();
    req[0] = 0;
    check("lit.s1_pc_load", 32'(pcload[0]), 32'h1);
    check("lit.s1_pc_next", pcnext[0], 32'h8C);
    cyc_();
    check("lit.s1_in_handler", 32'(inh[0]), 32'h1);
    check("lit.s1_lost", 32'(lost[0]), 32'h1);
    req[0] = 4'b0001; pcx[0] = 32'h999; cyc_();
    req[0] = 0; cyc_();
    check("lit.nest_epc", o_epc[0], 32'h40);

    // Return from exception; repeated eret ignored
    er[0] = 1; cyc_();
    check("lit.eret_pc_load", 32'(pcload[0]), 32'h1);
    check("lit.eret_pc_next", pcnext[0], 32'h40);
    check("lit.eret_in_handler", 32'(inh[0]), 32'h0);
    cyc_();
    check("lit.eret2_pc_load", 32'(pcload[0]), 32'h0);
    cyc_();
    er[0] = 0; cyc_();
    check("lit.eret3_pc_load", 32'(pcload[0]), 32'h0);

    // Priority with simultaneous requests
    rst[0] = 1; cyc_();
    rst[0] = 0;
    check("lit.prio_lost_before", 32'(lost[0]), 32'h0);
    req[0] = 4'b1010; pcx[0] = 32'h100; cyc_();
    req[0] = 0;
    check("lit.prio_cause", o_cause[0], 32'h1);
    check("lit.prio_addr", rdaddr[0], 32'd255);
    check("lit.prio_lost", 32'(lost[0]), 32'h1);
    repeat (3) cyc_();

    // eret and request together: eret wins
    er[0] = 1; req[0] = 4'b0100; cyc_();
    er[0] = 0; req[0] = 0;
    check("lit.eret_wins_next", pcnext[0], 32'h100);
    cyc_();

    // Remaining causes, including vector addresses past 255
    for (int j = 0; j < 3; j++) begin
      int k;
      k = (j == 0) ? 3 : (j == 1) ? 2 : 0;
      req[0] = 4'(1 << k); pcx[0] = 32'h300 + 32'(k); cyc_();
      req[0] = 0;
      repeat (2) cyc_();
      check($sformatf("lit.cause%0d_pc_next", k), pcnext[0], {24'h0, vec_lit[j]});
      cyc_();
      er[0] = 1; cyc_();
      er[0] = 0; cyc_();
    end

    // Memory latency 3
    req[1] = 4'b0001; pcx[1] = 32'h200; cyc_();
    req[1] = 0;
    check("lit.l3_rdreq1", 32'(rdreq[1]), 32'h1);
    check("lit.l3_addr", rdaddr[1], 32'd254);
    cyc_();
    check("lit.l3_rdreq2", 32'(rdreq[1]), 32'h0);
    repeat (2) cyc_();
    check("lit.l3_busy4", 32'(bsy[1]), 32'h1);
    check("lit.l3_pc_load4", 32'(pcload[1]), 32'h0);
    cyc_();
    check("lit.l3_pc_load5", 32'(pcload[1]), 32'h1);
    check("lit.l3_pc_next", pcnext[1], 32'h77);
    cyc_();
    check("lit.l3_busy6", 32'(bsy[1]), 32'h0);
    er[1] = 1; cyc_();
    er[1] = 0; cyc_();

    // Reset in VEC_WAIT aborts, then a fresh request is serviced
    req[1] = 4'b0100; pcx[1] = 32'h400; cyc_();
    req[1] = 0; cyc_();
    rst[1] = 1; cyc_();
    rst[1] = 0;
    check("lit.mid_rst_busy", 32'(bsy[1]), 32'h0);
    check("lit.mid_rst_epc", o_epc[1], 32'h0);
    check("lit.mid_rst_addr", rdaddr[1], 32'h0);
    repeat (3) cyc_();
    check("lit.mid_rst_no_load", 32'(pcload[1]), 32'h0);
    req[1] = 4'b0010; pcx[1] = 32'h500; cyc_();
    req[1] = 0;
    repeat (4) cyc_();
    check("lit.fresh_pc_load", 32'(pcload[1]), 32'h1);
    check("lit.fresh_pc_next", pcnext[1], 32'h8C);
    cyc_();
    check("lit.fresh_in_handler", 32'(inh[1]), 32'h1);

    repeat (3) cyc_();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
